// File: rtl/regfile_shift_unit.sv
// regfile_shift_unit
// Datapath slice of the multicycle RV64 core. It holds the 32x64 general
// register file, decodes the 6-bit immediate shift amount from the
// instruction word, and drives a combinational barrel shifter.
//  - The register file has two combinational read ports and one write port.
//    x0 always reads zero. A write lands on the rising clock edge, and there
//    is no read bypass.
//  - The shifter takes rs1 read data and shifts it by Inst[25:20]. It
//    supports SLL, SRL and SRA, and it can also pass the value through.
//  - Reset is asynchronous and clears the whole array. Outputs follow
//    straight away because every read path is combinational.
module regfile_shift_unit #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     reg_write_i,
    input  logic [$clog2(NREGS)-1:0] read_reg1_i,
    input  logic [$clog2(NREGS)-1:0] read_reg2_i,
    input  logic [$clog2(NREGS)-1:0] write_reg_i,
    input  logic [DATA_W-1:0]        write_data_i,
    output logic [DATA_W-1:0]        read_data1_o,
    output logic [DATA_W-1:0]        read_data2_o,
    input  logic [31:0]              inst_i,
    input  logic [1:0]               shift_i,
    output logic [5:0]               shift_n_o,
    output logic [DATA_W-1:0]        shift_out_o
);

    localparam int IDX_W = $clog2(NREGS);
    localparam int SH_W  = $clog2(DATA_W);

    // Shift operation encodings
    localparam logic [1:0] SH_SLL  = 2'b00;
    localparam logic [1:0] SH_SRL  = 2'b01;
    localparam logic [1:0] SH_SRA  = 2'b10;
    localparam logic [1:0] SH_PASS = 2'b11;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    // The array uses an asynchronous clear, so it is built from flops and
    // not from block RAM. Entry 0 exists only to keep the indexing simple.
    // It is never written and stays zero.
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  wr_sel;

    // x0 is hard-wired to zero, so it never gets a write strobe.
    assign wr_sel[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_wr_dec
            assign wr_sel[gi] = reg_write_i && (write_reg_i == IDX_W'(gi));
        end
    endgenerate

    // Next-state of the array: hold every entry except the one addressed by rd.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NREGS; i++) begin
            if (wr_sel[i]) begin
                regs_d[i] = write_data_i;
            end
        end
        regs_d[0] = '0;
    end

    // State update. An asynchronous reset clears all entries and takes
    // priority over a write on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Zero-latency reads. The x0 check is explicit so that x0 reads zero
    // no matter what entry 0 holds. A read of the index being written
    // returns the old value until the edge.
    always_comb begin
        read_data1_o = (read_reg1_i == '0) ? '0 : regs_q[read_reg1_i];
        read_data2_o = (read_reg2_i == '0) ? '0 : regs_q[read_reg2_i];
    end

    // ------------------------------------------------------------------
    // Shift-amount decode
    // ------------------------------------------------------------------
    // RV64 immediate shifts carry a 6-bit shamt in Inst[25:20]. The funct
    // bits and the register fields are not used here.
    logic unused_inst_bits;
    assign shift_n_o        = inst_i[25:20];
    assign unused_inst_bits = ^{inst_i[31:26], inst_i[19:0]};

    // ------------------------------------------------------------------
    // Barrel shifter
    // ------------------------------------------------------------------
    // A single logarithmic right-shifter serves all three shift ops.
    //  - For SLL, the operand is bit-reversed on the way in and again on
    //    the way out.
    //  - The fill bit is the sign bit for SRA and zero for the other ops.
    logic [DATA_W-1:0]            op_a;
    logic [DATA_W-1:0]            op_a_rev;
    logic [DATA_W-1:0]            shr_src;
    logic [DATA_W-1:0]            shr_res_rev;
    logic [SH_W:0][DATA_W-1:0]    shr_stage;
    logic [SH_W-1:0]              shamt;
    logic                         shr_fill;

    assign op_a     = read_data1_o;
    assign shamt    = shift_n_o[SH_W-1:0];
    assign shr_fill = (shift_i == SH_SRA) & op_a[DATA_W-1];
    assign shr_src  = (shift_i == SH_SLL) ? op_a_rev : op_a;

    // Bit-reversal networks on the SLL input and output paths
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_rev
            assign op_a_rev[gi]    = op_a[DATA_W-1-gi];
            assign shr_res_rev[gi] = shr_stage[SH_W][DATA_W-1-gi];
        end
    endgenerate

    // Shift stages. Stage gi shifts right by 2**gi when shamt bit gi is set.
    assign shr_stage[0] = shr_src;
    generate
        for (gi = 0; gi < SH_W; gi++) begin : g_stage
            localparam int STEP = 1 << gi;
            assign shr_stage[gi+1] = shamt[gi]
                ? {{STEP{shr_fill}}, shr_stage[gi][DATA_W-1:STEP]}
                : shr_stage[gi];
        end
    endgenerate

    // Select the result for the requested operation.
    always_comb begin
        shift_out_o = op_a;
        case (shift_i)
            SH_SLL:  shift_out_o = shr_res_rev;
            SH_SRL:  shift_out_o = shr_stage[SH_W];
            SH_SRA:  shift_out_o = shr_stage[SH_W];
            SH_PASS: shift_out_o = op_a;
            default: shift_out_o = op_a;
        endcase
    end

endmodule

// File: tb/tb_regfile_shift_unit.sv
// Directed testbench for regfile_shift_unit. A table of shifter vectors
// is run in a loop, followed by hand-written register-file sequences.
module tb_regfile_shift_unit;

    logic        clk_i;
    logic        rst_i;
    logic        reg_write_i;
    logic [4:0]  read_reg1_i;
    logic [4:0]  read_reg2_i;
    logic [4:0]  write_reg_i;
    logic [63:0] write_data_i;
    logic [63:0] read_data1_o;
    logic [63:0] read_data2_o;
    logic [31:0] inst_i;
    logic [1:0]  shift_i;
    logic [5:0]  shift_n_o;
    logic [63:0] shift_out_o;

    int total = 0;
    int bad   = 0;

    regfile_shift_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .reg_write_i  (reg_write_i),
        .read_reg1_i  (read_reg1_i),
        .read_reg2_i  (read_reg2_i),
        .write_reg_i  (write_reg_i),
        .write_data_i (write_data_i),
        .read_data1_o (read_data1_o),
        .read_data2_o (read_data2_o),
        .inst_i       (inst_i),
        .shift_i      (shift_i),
        .shift_n_o    (shift_n_o),
        .shift_out_o  (shift_out_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0] a;
        logic [31:0] inst;
        logic [1:0]  shift;
        logic [5:0]  exp_n;
        logic [63:0] exp_out;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(logic [63:0] a, logic [31:0] inst, logic [1:0] sh,
                                logic [5:0] n, logic [63:0] y);
        vec_t v;
        v.a = a; v.inst = inst; v.shift = sh; v.exp_n = n; v.exp_out = y;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [63:0] val);
        reg_write_i  = 1'b1;
        write_reg_i  = rd;
        write_data_i = val;
        tick();
        reg_write_i  = 1'b0;
    endtask

    initial begin
        // Shift vectors: operand, instruction word, op, expected shamt, expected result
        vecs[0]  = mk(64'h1, 32'h0040_0000, 2'b00, 6'd4,  64'h10);
        vecs[1]  = mk(64'h1, 32'h0040_0000, 2'b11, 6'd4,  64'h1);
        vecs[2]  = mk(64'h8000_0000_0000_0000, 32'h03F0_0000, 2'b01, 6'd63, 64'h1);
        vecs[3]  = mk(64'h8000_0000_0000_0000, 32'h03F0_0000, 2'b10, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF);
        vecs[4]  = mk(64'h8000_0000_0000_0000, 32'h0000_0000, 2'b01, 6'd0,  64'h8000_0000_0000_0000);
        vecs[5]  = mk(64'h8000_0000_0000_0000, 32'h0000_0000, 2'b10, 6'd0,  64'h8000_0000_0000_0000);
        vecs[6]  = mk(64'h8000_0000_0000_0000, 32'h0000_0000, 2'b00, 6'd0,  64'h8000_0000_0000_0000);
        vecs[7]  = mk(64'h8000_0000_0000_0000, 32'h03F0_0000, 2'b00, 6'd63, 64'h0);
        vecs[8]  = mk(64'h1, 32'h03F0_0000, 2'b00, 6'd63, 64'h8000_0000_0000_0000);
        vecs[9]  = mk(64'hDEAD_BEEF_CAFE_F00D, 32'h0080_0000, 2'b01, 6'd8,  64'h00DE_ADBE_EFCA_FEF0);
        vecs[10] = mk(64'hDEAD_BEEF_CAFE_F00D, 32'h0080_0000, 2'b10, 6'd8,  64'hFFDE_ADBE_EFCA_FEF0);
        vecs[11] = mk(64'hDEAD_BEEF_CAFE_F00D, 32'h0080_0000, 2'b00, 6'd8,  64'hADBE_EFCA_FEF0_0D00);
        vecs[12] = mk(64'h0123_4567_89AB_CDEF, 32'h0040_0000, 2'b10, 6'd4,  64'h0012_3456_789A_BCDE);
        vecs[13] = mk(64'h1, 32'hFC5F_FFFF, 2'b00, 6'd5,  64'h20);
        vecs[14] = mk(64'hDEAD_BEEF_CAFE_F00D, 32'h0200_0000, 2'b01, 6'd32, 64'h0000_0000_DEAD_BEEF);
        vecs[15] = mk(64'h0000_0000_0000_00F0, 32'h0240_0000, 2'b01, 6'd36, 64'h0);

        // Reset state
        rst_i        = 1'b1;
        reg_write_i  = 1'b0;
        read_reg1_i  = 5'd5;
        read_reg2_i  = 5'd31;
        write_reg_i  = 5'd0;
        write_data_i = 64'h0;
        inst_i       = 32'h0;
        shift_i      = 2'b11;
        #3;
        chk("reset_rd1", read_data1_o, 64'h0);
        chk("reset_rd2", read_data2_o, 64'h0);
        chk("reset_shout", shift_out_o, 64'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // Write/read with old value visible before the edge
        reg_write_i  = 1'b1;
        write_reg_i  = 5'd3;
        write_data_i = 64'hDEAD_BEEF_CAFE_F00D;
        read_reg1_i  = 5'd3;
        read_reg2_i  = 5'd3;
        #1;
        chk("rw_before_edge", read_data1_o, 64'h0);
        tick();
        chk("rw_after_rd1", read_data1_o, 64'hDEAD_BEEF_CAFE_F00D);
        chk("rw_after_rd2", read_data2_o, 64'hDEAD_BEEF_CAFE_F00D);

        // Writes to x0 are ignored
        write_reg_i  = 5'd0;
        write_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
        read_reg1_i  = 5'd0;
        tick();
        chk("x0_reads_zero", read_data1_o, 64'h0);
        reg_write_i = 1'b0;

        // An edge with RegWrite low leaves x7 unchanged
        write_reg(5'd7, 64'hAAAA);
        write_reg_i  = 5'd7;
        write_data_i = 64'h55;
        reg_write_i  = 1'b0;
        read_reg1_i  = 5'd7;
        tick();
        chk("no_write_x7", read_data1_o, 64'hAAAA);
        read_reg2_i = 5'd3;
        #1;
        chk("x3_retained", read_data2_o, 64'hDEAD_BEEF_CAFE_F00D);

        // Shifter vectors, with the operand loaded into x1
        for (int i = 0; i < 16; i++) begin
            write_reg(5'd1, vecs[i].a);
            read_reg1_i = 5'd1;
            inst_i      = vecs[i].inst;
            shift_i     = vecs[i].shift;
            #1;
            chk($sformatf("vec%0d_shiftn", i), {58'h0, shift_n_o}, {58'h0, vecs[i].exp_n});
            chk($sformatf("vec%0d_shiftout", i), shift_out_o, vecs[i].exp_out);
        end

        // Reset mid-run, asserted between edges, clears x5 straight away
        write_reg(5'd5, 64'h1234);
        read_reg1_i = 5'd5;
        read_reg2_i = 5'd3;
        shift_i     = 2'b11;
        #1;
        chk("x5_before_reset", read_data1_o, 64'h1234);
        #2;
        rst_i = 1'b1;
        #1;
        chk("midreset_rd1", read_data1_o, 64'h0);
        chk("midreset_rd2", read_data2_o, 64'h0);
        chk("midreset_shout", shift_out_o, 64'h0);

        // Reset wins over a simultaneous write
        reg_write_i  = 1'b1;
        write_reg_i  = 5'd5;
        write_data_i = 64'h99;
        tick();
        chk("reset_priority", read_data1_o, 64'h0);
        reg_write_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        chk("post_reset_x5", read_data1_o, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
